// File: rtl/kf_frame_if.sv
// kf_frame_if: frame-control bus between a frame requester/datapath (master) and kf_frame_ctrl (slave).
// Parameters: N word width, CH channel count (state vectors are CH*N bits, channel 0 in the LSBs).
// Master drives: start_valid, abort, init_we, x_init, x_post.
// Slave drives:  start_ready, x_prev, busy, cyc, ph_pred, ph_gain, ph_upd, done, frame_cnt.
interface kf_frame_if #(
    parameter int N  = 16,
    parameter int CH = 2
);
    logic              start_valid;
    logic              start_ready;
    logic              abort;
    logic              init_we;
    logic [CH*N-1:0]   x_init;
    logic [CH*N-1:0]   x_post;
    logic [CH*N-1:0]   x_prev;
    logic              busy;
    logic [7:0]        cyc;
    logic              ph_pred;
    logic              ph_gain;
    logic              ph_upd;
    logic              done;
    logic [15:0]       frame_cnt;

    modport master (
        output start_valid, abort, init_we, x_init, x_post,
        input  start_ready, x_prev, busy, cyc, ph_pred, ph_gain, ph_upd, done, frame_cnt
    );

    modport slave (
        input  start_valid, abort, init_we, x_init, x_post,
        output start_ready, x_prev, busy, cyc, ph_pred, ph_gain, ph_upd, done, frame_cnt
    );
endinterface

// File: rtl/kf_frame_ctrl.sv
// kf_frame_ctrl: Kalman-filter frame sequencer (IDLE/RUN), phase flags, prior-state commit and frame counter.
// Ports: clk clock; rst_n async active-low reset; bus kf_frame_if.slave carrying the start handshake,
//        abort, initial-state load, posterior/prior state, busy/cyc/phase flags, done pulse and frame count.
// Optional feature: define KF_FRAME_B2B_EN to accept a new start during the done cycle (back-to-back frames).
module kf_frame_ctrl #(
    parameter int N         = 16,
    parameter int CH        = 2,
    parameter int FRAME_LEN = 34,
    parameter int T_GAIN    = 12,
    parameter int T_UPD     = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    kf_frame_if.slave  bus
);
    localparam int         W      = CH * N;
    localparam logic [7:0] LAST   = 8'(FRAME_LEN - 1);
    localparam logic [7:0] C_GAIN = 8'(T_GAIN);
    localparam logic [7:0] C_UPD  = 8'(T_UPD);

    typedef enum logic {IDLE, RUN} state_e;

    state_e        state_q, state_d;
    logic [7:0]    cyc_q, cyc_d;
    logic [W-1:0]  x_prev_q, x_prev_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          run, last, done, ready, accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cyc_q       <= '0;
            x_prev_q    <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            x_prev_q    <= x_prev_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        run         = state_q == RUN;
        last        = run && cyc_q == LAST;
        // abort in the final cycle suppresses done, which in turn blocks the commit and any b2b acceptance
        done        = last && !bus.abort;
`ifdef KF_FRAME_B2B_EN
        ready       = !run || done;
`else
        ready       = !run;
`endif
        accept      = bus.start_valid && ready;
        state_d     = state_q;
        cyc_d       = cyc_q;
        x_prev_d    = x_prev_q;
        frame_cnt_d = frame_cnt_q;
        if (!run) begin
            // a load on the accepting edge is visible from C0 of the new frame
            if (bus.init_we) x_prev_d = bus.x_init;
            if (accept) begin
                state_d = RUN;
                cyc_d   = '0;
            end
        end else if (bus.abort) begin
            state_d = IDLE;
            cyc_d   = '0;
        end else if (last) begin
            x_prev_d    = bus.x_post;
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = accept ? RUN : IDLE;
            cyc_d       = '0;
        end else begin
            cyc_d = cyc_q + 8'd1;
        end
    end

    assign bus.start_ready = ready;
    assign bus.busy        = run;
    assign bus.cyc         = cyc_q;
    assign bus.ph_pred     = run && cyc_q < C_GAIN;
    assign bus.ph_gain     = run && cyc_q >= C_GAIN && cyc_q < C_UPD;
    assign bus.ph_upd      = run && cyc_q >= C_UPD;
    assign bus.done        = done;
    assign bus.x_prev      = x_prev_q;
    assign bus.frame_cnt   = frame_cnt_q;
endmodule
